// File: rtl/vga_sync_monitor.sv
// VGA sync sink: recovers beam position, checks line/frame timing, locks, and reports grid cell.
// Optional macro VGA_MON_PULSE_CHECK_EN adds hsync/vsync high-width checking.
`timescale 1ns/1ps
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_SYNC      = 96,
  parameter int V_SYNC      = 2,
  parameter int GRID_X0     = 225,
  parameter int GRID_Y0     = 36,
  parameter int CELL        = 30,
  parameter int GRID_N      = 16,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       bright_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       locked,
  output logic       frame_start,
  output logic       line_err,
  output logic       frame_err,
  output logic       cell_valid,
  output logic [4:0] cell_row,
  output logic [4:0] cell_col
);
  localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  state_t state_reg, state_next;
  logic [3:0] good_reg, good_next;

  logic hs_d, vs_d, h_seen_reg, le_seen_reg, vbad_reg;
  logic hs_rise, vs_rise, line_step, line_err_now, frame_ok, frame_err_now;
  logic hw_err, vw_err;
  logic [9:0] x_reg, x_next, y_reg, y_next;
  logic [CW-1:0] cx_reg, cx_next, cy_reg, cy_next;
  logic [4:0] col_reg, col_next, row_reg, row_next;
  logic col_act_reg, col_act_next, row_act_reg, row_act_next;
  logic locked_reg, frame_start_reg, line_err_reg, frame_err_reg;
  logic cell_valid_reg, cell_valid_next;
  logic [4:0] cell_row_reg, cell_col_reg;

  assign hs_rise   = pix_en & hsync_in & ~hs_d;
  assign vs_rise   = pix_en & vsync_in & ~vs_d;
  assign line_step = hs_rise | vs_rise;

`ifdef VGA_MON_PULSE_CHECK_EN
  // Width counters: samples with hsync high, and lines started while vsync is high.
  logic [9:0] hw_reg, vw_reg;
  logic hs_fall, vs_fall;
  assign hs_fall = pix_en & ~hsync_in & hs_d;
  assign vs_fall = pix_en & ~vsync_in & vs_d;
  assign hw_err  = hs_fall & (hw_reg != 10'(H_SYNC));
  assign vw_err  = vs_fall & (vw_reg != 10'(V_SYNC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_reg <= '0;
      vw_reg <= '0;
    end else if (pix_en) begin
      if (hs_rise)
        hw_reg <= 10'd1;
      else if (hsync_in && hw_reg != '1)
        hw_reg <= hw_reg + 10'd1;
      if (vs_rise)
        vw_reg <= 10'd1;
      else if (vsync_in && hs_rise && vw_reg != '1)
        vw_reg <= vw_reg + 10'd1;
    end
  end
`else
  assign hw_err = 1'b0;
  assign vw_err = 1'b0;
`endif

  assign line_err_now = (hs_rise & h_seen_reg & (x_reg != 10'(H_TOTAL - 1))) | hw_err;
  // The line ending at a vsync rise still belongs to the frame being judged.
  assign frame_ok = (y_reg == 10'(V_TOTAL - 1)) & ~le_seen_reg & ~line_err_now & ~vbad_reg;

  always_comb begin
    x_next = x_reg;
    if (hs_rise)
      x_next = '0;
    else if (x_reg == 10'(H_TOTAL - 1))
      x_next = '0;
    else
      x_next = x_reg + 10'd1;

    y_next = y_reg;
    if (vs_rise)
      y_next = '0;
    else if (hs_rise)
      y_next = (y_reg == 10'(V_TOTAL - 1)) ? 10'd0 : y_reg + 10'd1;
  end

  // Running cell counters follow the next beam position so indices line up with x/y.
  always_comb begin
    cx_next      = cx_reg;
    col_next     = col_reg;
    col_act_next = col_act_reg;
    if (x_next == 10'(GRID_X0)) begin
      cx_next      = '0;
      col_next     = '0;
      col_act_next = 1'b1;
    end else if (x_next == 10'd0) begin
      col_act_next = 1'b0;
    end else if (col_act_reg) begin
      if (cx_reg == CW'(CELL - 1)) begin
        cx_next  = '0;
        col_next = col_reg + 5'd1;
        if (col_reg == 5'(GRID_N - 1))
          col_act_next = 1'b0;
      end else begin
        cx_next = cx_reg + CW'(1);
      end
    end

    cy_next      = cy_reg;
    row_next     = row_reg;
    row_act_next = row_act_reg;
    if (line_step) begin
      if (y_next == 10'(GRID_Y0)) begin
        cy_next      = '0;
        row_next     = '0;
        row_act_next = 1'b1;
      end else if (y_next == 10'd0) begin
        row_act_next = 1'b0;
      end else if (row_act_reg) begin
        if (cy_reg == CW'(CELL - 1)) begin
          cy_next  = '0;
          row_next = row_reg + 5'd1;
          if (row_reg == 5'(GRID_N - 1))
            row_act_next = 1'b0;
        end else begin
          cy_next = cy_reg + CW'(1);
        end
      end
    end

    cell_valid_next = (state_next == LOCKED) & bright_in & col_act_next & row_act_next;
  end

  always_comb begin
    state_next    = state_reg;
    good_next     = good_reg;
    frame_err_now = 1'b0;
    if (vs_rise) begin
      case (state_reg)
        SEARCH: begin
          state_next = TRACK;
          good_next  = '0;
        end
        TRACK: begin
          if (frame_ok) begin
            good_next = good_reg + 4'd1;
            if (good_reg + 4'd1 >= 4'(LOCK_FRAMES))
              state_next = LOCKED;
          end else begin
            frame_err_now = 1'b1;
            good_next     = '0;
          end
        end
        LOCKED: begin
          if (!frame_ok) begin
            frame_err_now = 1'b1;
            state_next    = TRACK;
            good_next     = '0;
          end
        end
        default: begin
          state_next = SEARCH;
          good_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= SEARCH;
      good_reg  <= '0;
    end else begin
      state_reg <= state_next;
      good_reg  <= good_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d            <= 1'b0;
      vs_d            <= 1'b0;
      h_seen_reg      <= 1'b0;
      le_seen_reg     <= 1'b0;
      vbad_reg        <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      cx_reg          <= '0;
      cy_reg          <= '0;
      col_reg         <= '0;
      row_reg         <= '0;
      col_act_reg     <= 1'b0;
      row_act_reg     <= 1'b0;
      locked_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
      line_err_reg    <= 1'b0;
      frame_err_reg   <= 1'b0;
      cell_valid_reg  <= 1'b0;
      cell_row_reg    <= '0;
      cell_col_reg    <= '0;
    end else begin
      frame_start_reg <= 1'b0;
      line_err_reg    <= 1'b0;
      frame_err_reg   <= 1'b0;
      if (pix_en) begin
        hs_d            <= hsync_in;
        vs_d            <= vsync_in;
        if (hs_rise)
          h_seen_reg <= 1'b1;
        le_seen_reg     <= vs_rise ? 1'b0 : (le_seen_reg | line_err_now);
        vbad_reg        <= vs_rise ? 1'b0 : (vbad_reg | vw_err);
        x_reg           <= x_next;
        y_reg           <= y_next;
        cx_reg          <= cx_next;
        cy_reg          <= cy_next;
        col_reg         <= col_next;
        row_reg         <= row_next;
        col_act_reg     <= col_act_next;
        row_act_reg     <= row_act_next;
        locked_reg      <= (state_next == LOCKED);
        frame_start_reg <= vs_rise;
        line_err_reg    <= line_err_now;
        frame_err_reg   <= frame_err_now;
        cell_valid_reg  <= cell_valid_next;
        cell_row_reg    <= cell_valid_next ? row_next : 5'd0;
        cell_col_reg    <= cell_valid_next ? col_next : 5'd0;
      end
    end
  end

  assign x           = x_reg;
  assign y           = y_reg;
  assign locked      = locked_reg;
  assign frame_start = frame_start_reg;
  assign line_err    = line_err_reg;
  assign frame_err   = frame_err_reg;
  assign cell_valid  = cell_valid_reg;
  assign cell_row    = cell_row_reg;
  assign cell_col    = cell_col_reg;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Randomised-timing bench for vga_sync_monitor on a scaled-down raster, checked every cycle
// against a position/frame-level reference model.
`timescale 1ns/1ps
module tb_vga_sync_monitor;
  localparam int TH = 40, TV = 20, THS = 4, TVS = 2;
  localparam int TX0 = 16, TY0 = 3, TCELL = 3, TN = 4, TLOCK = 2;

  logic clk = 1'b0;
  logic rst, pix_en, hsync_in, vsync_in, bright_in;
  logic [9:0] x, y;
  logic locked, frame_start, line_err, frame_err, cell_valid;
  logic [4:0] cell_row, cell_col;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_TOTAL(TH), .V_TOTAL(TV), .H_SYNC(THS), .V_SYNC(TVS),
    .GRID_X0(TX0), .GRID_Y0(TY0), .CELL(TCELL), .GRID_N(TN), .LOCK_FRAMES(TLOCK)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .bright_in(bright_in), .x(x), .y(y), .locked(locked), .frame_start(frame_start),
    .line_err(line_err), .frame_err(frame_err), .cell_valid(cell_valid),
    .cell_row(cell_row), .cell_col(cell_col)
  );

  int n_cmp = 0, n_bad = 0;
  int le_cnt = 0, fe_cnt = 0, fs_cnt = 0, n_frames = 0;
  int hit_org = 0, hit_11 = 0, hit_out = 0, hit_last = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0d model=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beam position, frame judgement and lock mode in plain integers.
  int m_x, m_y, mode, good;
  bit hs_p, vs_p, h_seen, le_since, vbad;
  int e_x, e_y, e_row, e_col;
  bit e_locked, e_fs, e_le, e_fe, e_cv;

  task automatic model_reset();
    m_x = 0; m_y = 0; mode = 0; good = 0;
    hs_p = 0; vs_p = 0; h_seen = 0; le_since = 0; vbad = 0;
    e_x = 0; e_y = 0; e_row = 0; e_col = 0;
    e_locked = 0; e_fs = 0; e_le = 0; e_fe = 0; e_cv = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs, input bit br);
    bit hr, vr, le, bad;
    int y_old;
    hr = hs && !hs_p;
    vr = vs && !vs_p;
    le = hr && h_seen && (m_x != TH - 1);
    if (hr) begin
      m_x = 0;
      h_seen = 1;
    end else begin
      m_x = (m_x + 1) % TH;
    end
`ifdef VGA_MON_PULSE_CHECK_EN
    if (!hs && hs_p && m_x != THS) le = 1;
`endif
    y_old = m_y;
    e_fs = vr;
    e_fe = 0;
    if (vr) begin
      bad = le || le_since || vbad || (y_old != TV - 1);
      m_y = 0; le_since = 0; vbad = 0;
      if (mode == 0) begin
        mode = 1; good = 0;
      end else if (bad) begin
        if (mode != 0) e_fe = 1;
        mode = 1; good = 0;
      end else if (mode == 1) begin
        good++;
        if (good >= TLOCK) mode = 2;
      end
    end else begin
      if (hr) m_y = (m_y + 1) % TV;
      le_since = le_since || le;
    end
`ifdef VGA_MON_PULSE_CHECK_EN
    if (!vs && vs_p && m_y != TVS) vbad = 1;
`endif
    e_le = le;
    hs_p = hs;
    vs_p = vs;
    e_x = m_x;
    e_y = m_y;
    e_locked = (mode == 2);
    e_cv = 0; e_row = 0; e_col = 0;
    if (e_locked && br && m_x >= TX0 && m_y >= TY0 &&
        (m_x - TX0) / TCELL < TN && (m_y - TY0) / TCELL < TN) begin
      e_cv = 1;
      e_row = (m_y - TY0) / TCELL;
      e_col = (m_x - TX0) / TCELL;
    end
  endtask

  bit s_rst, s_pe, s_hs, s_vs, s_br;
  always @(posedge clk) begin
    s_rst = rst; s_pe = pix_en; s_hs = hsync_in; s_vs = vsync_in; s_br = bright_in;
    if (s_rst) begin
      model_reset();
    end else begin
      e_fs = 0; e_le = 0; e_fe = 0;
      if (s_pe) model_step(s_hs, s_vs, s_br);
    end
    #1;
    chk("x", x, e_x);
    chk("y", y, e_y);
    chk("locked", locked, e_locked);
    chk("frame_start", frame_start, e_fs);
    chk("line_err", line_err, e_le);
    chk("frame_err", frame_err, e_fe);
    chk("cell_valid", cell_valid, e_cv);
    chk("cell_row", cell_row, e_row);
    chk("cell_col", cell_col, e_col);
    if (line_err) le_cnt++;
    if (frame_err) fe_cnt++;
    if (frame_start) fs_cnt++;
    if (!s_rst && s_pe && e_locked && s_br) begin
      if (m_x == TX0 && m_y == TY0) begin
        hit_org++;
        chk("cell_origin_valid", cell_valid, 1);
        chk("cell_origin_row", cell_row, 0);
        chk("cell_origin_col", cell_col, 0);
      end
      if (m_x == TX0 + TCELL && m_y == TY0 + TCELL) begin
        hit_11++;
        chk("cell_11_row", cell_row, 1);
        chk("cell_11_col", cell_col, 1);
      end
      if (m_x == TX0 + TN * TCELL && m_y == TY0) begin
        hit_out++;
        chk("cell_right_edge_valid", cell_valid, 0);
      end
      if (m_x == TX0 + TN * TCELL - 1 && m_y == TY0) begin
        hit_last++;
        chk("cell_last_col", cell_col, TN - 1);
      end
    end
  end

  task automatic drive_pixel(input bit hs, input bit vs, input bit br);
    hsync_in = hs; vsync_in = vs; bright_in = br; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    hsync_in = 1'($urandom); vsync_in = 1'($urandom); bright_in = 1'($urandom);
    repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  task automatic run_frame(input int nlines, input int short_line, input int hs_w, input int rst_line);
    int len;
    bit act;
    n_frames++;
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? TH - 1 : TH;
      for (int p = 0; p < len; p++) begin
        if (l == rst_line && p == 20) begin
          chk("locked_before_rst", locked, 1);
          rst = 1'b1;
          #1;
          chk("rst_x", x, 0);
          chk("rst_y", y, 0);
          chk("rst_locked", locked, 0);
          chk("rst_cell_valid", cell_valid, 0);
          @(negedge clk);
          @(negedge clk);
          rst = 1'b0;
        end
        act = (p >= 6 && p < TH - 2 && l >= 2 && l < TV - 1);
        drive_pixel(p < hs_w, l < TVS, act && ($urandom_range(0, 7) != 0));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int le_base, fe_base;
    rst = 1'b1; pix_en = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; bright_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_x", x, 0);
    chk("reset_y", y, 0);
    chk("reset_locked", locked, 0);
    chk("reset_cell_valid", cell_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(TV, -1, THS, -1);
    chk("first_frame_no_frame_err", fe_cnt, 0);
    run_frame(TV, -1, THS, -1);
    chk("unlocked_after_2nd_rise", locked, 0);
    run_frame(TV, -1, THS, -1);
    chk("locked_after_3rd_rise", locked, 1);
    run_frame(TV, -1, THS, -1);
    chk("nominal_line_err_count", le_cnt, 0);
    chk("nominal_frame_err_count", fe_cnt, 0);

    run_frame(TV, 5, THS, -1);
    chk("short_line_line_err", le_cnt, 1);
    chk("short_line_still_locked", locked, 1);
    run_frame(TV, -1, THS, -1);
    chk("short_line_frame_err", fe_cnt, 1);
    chk("short_line_unlock", locked, 0);
    run_frame(TV, -1, THS, -1);
    chk("relock_pending", locked, 0);
    run_frame(TV, -1, THS, -1);
    chk("relock_after_two_good", locked, 1);

    run_frame(TV - 1, -1, THS, -1);
    run_frame(TV, -1, THS, -1);
    chk("short_frame_frame_err", fe_cnt, 2);
    chk("short_frame_unlock", locked, 0);
    run_frame(TV, -1, THS, -1);
    run_frame(TV, -1, THS, -1);
    chk("short_frame_relock", locked, 1);

    le_base = le_cnt;
    fe_base = fe_cnt;
    run_frame(TV, -1, THS - 1, -1);
`ifdef VGA_MON_PULSE_CHECK_EN
    chk("narrow_hsync_line_err", le_cnt - le_base, TV);
`else
    chk("narrow_hsync_line_err", le_cnt - le_base, 0);
`endif
    run_frame(TV, -1, THS, -1);
    run_frame(TV, -1, THS, -1);
    run_frame(TV, -1, THS, -1);
`ifdef VGA_MON_PULSE_CHECK_EN
    chk("narrow_hsync_frame_err", fe_cnt - fe_base, 1);
`else
    chk("narrow_hsync_frame_err", fe_cnt - fe_base, 0);
`endif
    chk("locked_before_reset_test", locked, 1);

    fe_base = fe_cnt;
    run_frame(TV, -1, THS, 5);
    chk("after_rst_unlocked", locked, 0);
    run_frame(TV, -1, THS, -1);
    chk("after_rst_no_frame_err", fe_cnt - fe_base, 0);
    run_frame(TV, -1, THS, -1);
    chk("after_rst_tracking", locked, 0);
    run_frame(TV, -1, THS, -1);
    chk("after_rst_relock", locked, 1);
    chk("after_rst_frame_err_total", fe_cnt - fe_base, 0);

    chk("frame_start_count", fs_cnt, n_frames);
    chk("cell_origin_seen", int'(hit_org > 0), 1);
    chk("cell_11_seen", int'(hit_11 > 0), 1);
    chk("cell_edge_seen", int'(hit_out > 0), 1);
    chk("cell_last_seen", int'(hit_last > 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
